// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: time-step strobe, currents, threshold,
// monitor select and counter clear in; spikes, monitored membrane and
// population count out.
interface lif_neuron_array_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;

  logic                 en;
  logic [N*WIDTH-1:0]   current;
  logic [WIDTH-1:0]     threshold;
  logic [SelW-1:0]      sel;
  logic                 cnt_clr;
  logic [N-1:0]         spike;
  logic [WIDTH-1:0]     state_out;
  logic [15:0]          spike_count;

  modport master (
    output en, current, threshold, sel, cnt_clr,
    input  spike, state_out, spike_count
  );

  modport slave (
    input  en, current, threshold, sel, cnt_clr,
    output spike, state_out, spike_count
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of N leaky integrate-and-fire neurons updated in lock-step on the
// en strobe. Shared threshold, shift leak, saturating membrane, per-neuron
// refractory counter and a saturating population spike counter.
module lif_neuron_array #(
  parameter int unsigned N          = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRAC     = 2
) (
  input logic               clk,
  input logic               rst_n,
  lif_neuron_array_if.slave bus
);
  localparam logic [3:0]       RefracInit = 4'(REFRAC);
  localparam logic [WIDTH-1:0] SatMax     = '1;

  logic [WIDTH-1:0] r_state  [N];
  logic [3:0]       r_refrac [N];
  logic [N-1:0]     r_spike;
  logic [15:0]      r_count;

  logic [WIDTH:0]   w_sum  [N];
  logic [WIDTH-1:0] w_next [N];
  logic [N-1:0]     w_fire;
  logic [4:0]       w_pop;
  logic [16:0]      w_cnt_sum;
  logic [WIDTH-1:0] w_state_out;

  // Leak + integrate in WIDTH+1 bits, saturate, then compare the saturated value.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      w_sum[i]  = {1'b0, r_state[i]} - {1'b0, (r_state[i] >> LEAK_SHIFT)}
                + {1'b0, bus.current[i*WIDTH +: WIDTH]};
      w_next[i] = w_sum[i][WIDTH] ? SatMax : w_sum[i][WIDTH-1:0];
      w_fire[i] = (w_next[i] >= bus.threshold);
    end
  end

  // Per-neuron state: hold without en, refractory blanking, or integrate/fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        r_state[i]  <= '0;
        r_refrac[i] <= '0;
      end
      r_spike <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (!bus.en) begin
          r_spike[i] <= 1'b0;
        end else if (r_refrac[i] != 4'd0) begin
          r_state[i]  <= '0;
          r_refrac[i] <= r_refrac[i] - 4'd1;
          r_spike[i]  <= 1'b0;
        end else if (w_fire[i]) begin
          r_state[i]  <= '0;
          r_refrac[i] <= RefracInit;
          r_spike[i]  <= 1'b1;
        end else begin
          r_state[i]  <= w_next[i];
          r_spike[i]  <= 1'b0;
        end
      end
    end
  end

  // Popcount of the registered spikes feeds the counter one cycle later.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_pop = w_pop + 5'(r_spike[i]);
    end
    w_cnt_sum = {1'b0, r_count} + 17'(w_pop);
  end

  // Saturating population counter; clear beats the same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (bus.cnt_clr) begin
      r_count <= '0;
    end else if (w_cnt_sum[16]) begin
      r_count <= 16'hFFFF;
    end else begin
      r_count <= w_cnt_sum[15:0];
    end
  end

  // Membrane monitor mux; out-of-range select reads as zero.
  always_comb begin
    w_state_out = '0;
    if (32'(bus.sel) < N) begin
      w_state_out = r_state[bus.sel];
    end
  end

  assign bus.spike       = r_spike;
  assign bus.state_out   = w_state_out;
  assign bus.spike_count = r_count;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array (N=4, WIDTH=8, LEAK_SHIFT=1, REFRAC=2).
module tb_lif_neuron_array;
  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  lif_neuron_array_if #(.N(4), .WIDTH(8)) bus ();

  lif_neuron_array #(
    .N(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One en step; outputs are sampled 1 ns after the edge.
  task automatic step();
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int leak_exp [8] = '{40, 60, 70, 75, 78, 79, 80, 80};

  initial begin
    tests = 0;
    failed = 0;

    // Reset with random inputs
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.current   = 32'($urandom);
    bus.threshold = 8'($urandom);
    bus.sel       = 2'($urandom);
    bus.cnt_clr   = 1'b0;
    idle(3);
    check("rst_spike", 32'(bus.spike), 0);
    check("rst_state", 32'(bus.state_out), 0);
    check("rst_count", 32'(bus.spike_count), 0);
    rst_n  = 1'b1;
    bus.en = 1'b0;
    bus.sel = 2'd0;
    idle(5);
    check("hold_spike", 32'(bus.spike), 0);
    check("hold_state", 32'(bus.state_out), 0);
    check("hold_count", 32'(bus.spike_count), 0);

    // Leak convergence on ch0
    bus.threshold = 8'd100;
    bus.current   = {8'd0, 8'd0, 8'd0, 8'd40};
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("leak_%0d", k), 32'(bus.state_out), 32'(leak_exp[k]));
    end
    check("leak_nospike", 32'(bus.spike), 0);

    // Fire and refractory on ch0
    pulse_reset();
    bus.current = {8'd0, 8'd0, 8'd0, 8'd60};
    step();
    check("fire_s1", 32'(bus.state_out), 60);
    step();
    check("fire_s2", 32'(bus.state_out), 90);
    step();
    check("fire_s3_spike", 32'(bus.spike), 32'h1);
    check("fire_s3_state", 32'(bus.state_out), 0);
    step();
    check("fire_s4_state", 32'(bus.state_out), 0);
    check("fire_s4_spike", 32'(bus.spike), 0);
    step();
    check("fire_s5_state", 32'(bus.state_out), 0);
    check("fire_s5_spike", 32'(bus.spike), 0);
    step();
    check("fire_s6_state", 32'(bus.state_out), 60);

    // Hold with en low, then reset mid-refractory
    pulse_reset();
    step();
    step();
    check("hold90_pre", 32'(bus.state_out), 90);
    idle(4);
    check("hold90_state", 32'(bus.state_out), 90);
    check("hold90_spike", 32'(bus.spike), 0);
    step();
    check("midref_fire", 32'(bus.spike), 32'h1);
    pulse_reset();
    check("midref_rst_state", 32'(bus.state_out), 0);
    check("midref_rst_spike", 32'(bus.spike), 0);
    step();
    check("midref_resume", 32'(bus.state_out), 60);
    check("midref_resume_spike", 32'(bus.spike), 0);

    // Saturation on ch1 with threshold at full scale
    pulse_reset();
    bus.sel       = 2'd1;
    bus.threshold = 8'd255;
    bus.current   = {8'd0, 8'd0, 8'd200, 8'd0};
    step();
    check("sat_s1", 32'(bus.state_out), 200);
    check("sat_s1_spike", 32'(bus.spike), 0);
    step();
    check("sat_s2_spike", 32'(bus.spike), 32'h2);
    check("sat_s2_state", 32'(bus.state_out), 0);

    // Threshold 0 fires every integrating neuron
    pulse_reset();
    bus.threshold = 8'd0;
    bus.current   = '0;
    step();
    check("thr0_spike", 32'(bus.spike), 32'hF);

    // Counter: lag, clear priority, saturation
    pulse_reset();
    bus.sel       = 2'd0;
    bus.threshold = 8'd1;
    bus.current   = {8'd255, 8'd255, 8'd255, 8'd255};
    step();
    check("cnt_spike", 32'(bus.spike), 32'hF);
    check("cnt_lag", 32'(bus.spike_count), 0);
    idle(1);
    check("cnt_plus4", 32'(bus.spike_count), 4);
    step();
    step();
    check("cnt_refrac_hold", 32'(bus.spike_count), 4);
    step();
    check("cnt_refire", 32'(bus.spike), 32'hF);
    bus.cnt_clr = 1'b1;
    idle(1);
    bus.cnt_clr = 1'b0;
    check("cnt_clr", 32'(bus.spike_count), 0);
    step();
    step();
    bus.en = 1'b1;
    repeat (49149) @(posedge clk);
    #1;
    bus.en = 1'b0;
    check("cnt_bulk", 32'(bus.spike_count), 65532);
    bus.current = {8'd0, 8'd0, 8'd255, 8'd255};
    step();
    check("cnt_two_spike", 32'(bus.spike), 32'h3);
    idle(1);
    check("cnt_fffe", 32'(bus.spike_count), 32'hFFFE);
    step();
    step();
    bus.current = {8'd255, 8'd255, 8'd255, 8'd255};
    step();
    check("cnt_last_spike", 32'(bus.spike), 32'hF);
    idle(1);
    check("cnt_sat", 32'(bus.spike_count), 32'hFFFF);
    idle(2);
    check("cnt_sat_hold", 32'(bus.spike_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised array of N leaky integrate-and-fire neurons with shared programmable threshold, fixed-point shift leak, saturating membrane arithmetic, per-neuron refractory period and a saturating population spike counter. It is the multi-channel successor to the single `lifn` neuron. It sits between the input current bus and the `tt_um_*` top-level I/O. It is updated in lock-step on an external time-step strobe.

## Interface
- `N`, default 4: neuron count, 1..16.
- `WIDTH`, default 8: membrane/current/threshold width, 4..16.
- `LEAK_SHIFT`, default 1: leak per step is `state >> LEAK_SHIFT`; range 1..WIDTH-1.
- `REFRAC`, default 2: refractory steps after a spike, 0..15.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  time-step strobe; all neurons update on a rising `clk` edge with `en`=1.
- `current`  in  N*WIDTH  unsigned input current; neuron i uses bits [i*WIDTH +: WIDTH].
- `threshold`  in  WIDTH  unsigned firing threshold, shared by all neurons.
- `sel`  in  clog2(N) (min 1)  neuron index for `state_out`.
- `cnt_clr`  in  1  synchronous clear of `spike_count`.
- `spike`  out  N  registered spike flags, one per neuron.
- `state_out`  out  WIDTH  membrane of neuron `sel`; 0 if `sel` >= N.
- `spike_count`  out  16  saturating population spike total.

## Operation
- Per neuron registers: `state[WIDTH]`, `refrac[4]`, `spike`. Two states per neuron: INTEGRATE (`refrac`=0) and REFRACTORY (`refrac`>0).
- `en`=0: `state` and `refrac` hold. `spike` clears to 0.
- `en`=1 in REFRACTORY: `state` becomes 0. `refrac` decrements. `spike` becomes 0. `current` is ignored.
- `en`=1 in INTEGRATE: `next = state - (state >> LEAK_SHIFT) + current_i`. Compute in WIDTH+1 bits, then saturate to 2^WIDTH-1.
- If `next` >= `threshold`: `spike` becomes 1, `state` becomes 0, `refrac` becomes REFRAC (REFRAC=0 means no refractory period).
- Otherwise: `state` becomes `next` and `spike` becomes 0.
- `threshold`=0 makes every INTEGRATE step fire.
- The compare uses the saturated `next`. A saturated value equal to `threshold`=2^WIDTH-1 fires.
- `spike_count`: every edge, add popcount(`spike` register), saturating at 0xFFFF.
- `cnt_clr`=1 sets `spike_count` to 0 and discards that edge's increment (clear wins).
- `state_out` is a combinational mux of the registered `state`, with no added latency.

## Timing
- Reset (`rst_n`=0, asynchronous): all `state`, `refrac`, `spike` and `spike_count` are 0 immediately. `state_out`=0.
- Reset mid-refractory cancels the refractory period. First `en` after release integrates normally.
- Inputs are sampled at the rising edge with `en`=1. `spike` is visible after that edge and lasts exactly one cycle, unless the next cycle's `en` fires again. With REFRAC=0 that can make `spike` high on consecutive cycles.
- A `spike` bit is added to `spike_count` on the edge after it appears, so `spike_count` lags `spike` by one cycle.
- The spike-causing step plus REFRAC steps yield `state`=0. Integration resumes on step REFRAC+2.
- Back-to-back `en` every cycle is supported. `en` gaps stretch time, not behaviour.

## Test plan
- Reset: drive random inputs with `rst_n`=0 -> `spike`=0, `state_out`=0, `spike_count`=0. Release with `en`=0 for 5 cycles -> all hold 0.
- Leak convergence: WIDTH=8, LEAK_SHIFT=1, `threshold`=100, ch0 `current`=40, `en`=1 -> `state_out`(sel=0) sequence 40, 60, 70, 75, 78, 79, 80, 80; no spike.
- Fire and refractory: REFRAC=2, ch0 `current`=60, `threshold`=100 -> `state` 60, 90; step 3 `spike[0]`=1 and `state`=0; steps 4-5 `state`=0, no spike; step 6 `state`=60.
- Saturation: ch1 `current`=200, `threshold`=255 -> step 1 `state`=200; step 2 computes 300, saturates to 255 and fires; `spike[1]`=1.
- Hold, then reset mid-refractory: `en` low 4 cycles after `state`=90 -> `state` stays 90. Pulse `rst_n` during refractory, then `current`=60 -> first step gives 60.
- Counter: all 4 channels with `current`=255 and `threshold`=1, fire on the same step -> `spike_count` +4 one cycle later. Assert `cnt_clr` on the edge where the next group of spikes is counted -> `spike_count`=0. Preload to 0xFFFE via repeated firing -> `spike_count` saturates at 0xFFFF.
